// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: request kinds and the MIPS opcodes
// accepted by the main decoder.
package instr_pkg;

  typedef enum logic [2:0] {
    K_RTYPE   = 3'd0,
    K_LW      = 3'd1,
    K_SW      = 3'd2,
    K_BEQ     = 3'd3,
    K_ADDI    = 3'd4,
    K_J       = 3'd5,
    K_JAL     = 3'd6,
    K_ILLEGAL = 3'd7
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction kind plus fields into a 32-bit MIPS word.
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        legal_o,
  output logic [31:0] word_o
);

  always_comb begin
    legal_o = 1'b1;
    word_o  = '0;
    case (instr_kind_t'(kind_i))
      K_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      K_LW:    word_o = itype(OP_LW, rs_i, rt_i, imm_i);
      K_SW:    word_o = itype(OP_SW, rs_i, rt_i, imm_i);
      K_BEQ:   word_o = itype(OP_BEQ, rs_i, rt_i, imm_i);
      K_ADDI:  word_o = itype(OP_ADDI, rs_i, rt_i, imm_i);
      K_J:     word_o = {OP_J, target_i};
      K_JAL:   word_o = {OP_JAL, target_i};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requests into MIPS words and streams them with their byte
// addresses through a 2-entry output buffer.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned     n         = 32,
  parameter logic [n-1:0]    BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [n-1:0]  out_addr,
  output logic          illegal
);

  logic [31:0]  word_q [2];
  logic [31:0]  word_d [2];
  logic [n-1:0] addr_buf_q [2];
  logic [n-1:0] addr_buf_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [n-1:0] next_addr_q, next_addr_d;
  logic         illegal_q, illegal_d;

  logic         pack_legal;
  logic [31:0]  pack_word;
  logic         accept, push, pop;

  instr_pack u_pack (
    .kind_i   (in_kind),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .target_i (in_target),
    .legal_o  (pack_legal),
    .word_o   (pack_word)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_instr = word_q[rd_ptr_q];
  assign out_addr  = addr_buf_q[rd_ptr_q];
  assign illegal   = illegal_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && pack_legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    word_d      = word_q;
    addr_buf_d  = addr_buf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    illegal_d   = illegal_q;

    if (push) begin
      word_d[wr_ptr_q]     = pack_word;
      addr_buf_d[wr_ptr_q] = next_addr_q;
      wr_ptr_d             = ~wr_ptr_q;
      next_addr_d          = next_addr_q + n'(4);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept && !pack_legal) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q[0]     <= '0;
      word_q[1]     <= '0;
      addr_buf_q[0] <= BASE_ADDR;
      addr_buf_q[1] <= BASE_ADDR;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      next_addr_q   <= BASE_ADDR;
      illegal_q     <= 1'b0;
    end else begin
      word_q        <= word_d;
      addr_buf_q    <= addr_buf_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      next_addr_q   <= next_addr_d;
      illegal_q     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vectors, corner sequences and random traffic against a
// queue-based reference model; two instances differ only in base address.
module tb_instr_encoder;

  localparam logic [31:0] BASE_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_instr, out_addr;
  logic        in_ready_w, out_valid_w, illegal_w;
  logic [31:0] out_instr_w, out_addr_w;

  always #5 clk = ~clk;

  instr_encoder #(.n(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .illegal(illegal)
  );

  instr_encoder #(.n(32), .BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_instr(out_instr_w), .out_addr(out_addr_w), .illegal(illegal_w)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic [31:0] addr_w;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        exp_q[$];
  logic [31:0] seen[$];
  logic [31:0] seen_w[$];
  int unsigned m_addr, m_addr_w;
  bit          m_ill;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the opcode table and MIPS field positions.
  function automatic logic [31:0] ref_encode(logic [2:0] k, logic [4:0] rs, logic [4:0] rt,
                                             logic [4:0] rd, logic [4:0] sh, logic [5:0] fn,
                                             logic [15:0] imm, logic [25:0] tgt);
    int unsigned op_tab[7] = '{0, 35, 43, 4, 8, 2, 3};
    int unsigned w;
    w = op_tab[k] << 26;
    if (k == 3'd5 || k == 3'd6) w = w | int'(tgt);
    else begin
      w = w | (int'(rs) << 21) | (int'(rt) << 16);
      if (k == 3'd0) w = w | (int'(rd) << 11) | (int'(sh) << 6) | int'(fn);
      else w = w | int'(imm);
    end
    return w;
  endfunction

  task automatic step();
    bit acc, emit;
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("illegal", 64'(illegal), 64'(m_ill));
    check("in_ready_w", 64'(in_ready_w), 64'(exp_q.size() < 2));
    check("out_valid_w", 64'(out_valid_w), 64'(exp_q.size() != 0));
    check("illegal_w", 64'(illegal_w), 64'(m_ill));
    if (exp_q.size() != 0) begin
      check("out_instr", 64'(out_instr), 64'(exp_q[0].word));
      check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
      check("out_instr_w", 64'(out_instr_w), 64'(exp_q[0].word));
      check("out_addr_w", 64'(out_addr_w), 64'(exp_q[0].addr_w));
    end
    if (out_valid && out_ready) seen.push_back(out_addr);
    if (out_valid_w && out_ready) seen_w.push_back(out_addr_w);
    acc  = in_valid && (exp_q.size() < 2);
    emit = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_addr   = 0;
      m_addr_w = BASE_W;
      m_ill    = 1'b0;
    end else begin
      if (emit) void'(exp_q.pop_front());
      if (acc) begin
        if (in_kind == 3'd7) m_ill = 1'b1;
        else begin
          exp_q.push_back('{ref_encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
                                       in_imm, in_target), m_addr, m_addr_w});
          m_addr   = m_addr + 4;
          m_addr_w = m_addr_w + 4;
        end
      end
    end
    #1;
  endtask

  task automatic req(logic [2:0] k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                     logic [4:0] sh, logic [5:0] fn, logic [15:0] imm, logic [25:0] tgt);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_kind  = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{3'd4, 5'd0,  5'd8,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0,       32'h2008_0005};
    tbl[1] = '{3'd0, 5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'h0,    26'h0,       32'h0109_5020};
    tbl[2] = '{3'd1, 5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,       32'h8FA8_0004};
    tbl[3] = '{3'd2, 5'd29, 5'd31, 5'd3,  5'd7, 6'h11, 16'h0008, 26'h3FFFFFF, 32'hAFBF_0008};
    tbl[4] = '{3'd3, 5'd8,  5'd9,  5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0,       32'h1109_FFFF};
    tbl[5] = '{3'd5, 5'd1,  5'd2,  5'd3,  5'd4, 6'h05, 16'h1234, 26'h0100000, 32'h0810_0000};
    tbl[6] = '{3'd6, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0,    26'h0ABCDEF, 32'h0CAB_CDEF};

    reset = 1'b1; out_ready = 1'b1;
    req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    in_valid = 1'b0;
    m_addr = 0; m_addr_w = BASE_W; m_ill = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_addr_w", 64'(out_addr_w), 64'(BASE_W));
    check("rst_illegal", 64'(illegal), 64'd0);

    // Single vectors with an empty buffer: word must be on the outputs one cycle later.
    for (int i = 0; i < 7; i++) begin
      req(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].shamt, tbl[i].funct,
          tbl[i].imm, tbl[i].target);
      step();
      idle();
      check("tbl_valid", 64'(out_valid), 64'd1);
      check("tbl_word", 64'(out_instr), 64'(tbl[i].exp));
      step();
    end

    // Back-to-back RTYPE then LW.
    do_reset();
    req(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0);
    step();
    check("b2b_w0", 64'(out_instr), 64'h0109_5020);
    check("b2b_a0", 64'(out_addr), 64'h0);
    req(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
    step();
    idle();
    check("b2b_w1", 64'(out_instr), 64'h8FA8_0004);
    check("b2b_a1", 64'(out_addr), 64'h4);
    step(); step();

    // Backpressure: two accepts fill the buffer, outputs hold, then drain in order.
    do_reset();
    out_ready = 1'b0;
    req(3'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
    step();
    req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000);
    step();
    req(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
    check("bp_full", 64'(in_ready), 64'd0);
    step(); step();
    idle();
    step();
    check("bp_hold", 64'(out_instr), 64'h1109_FFFF);
    out_ready = 1'b1;
    step();
    check("bp_second", 64'(out_instr), 64'h0810_0000);
    check("bp_second_a", 64'(out_addr), 64'h4);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Illegal kind between two ADDIs.
    do_reset();
    seen.delete();
    req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    step();
    req(3'd7, 5'd3, 5'd3, 5'd3, 5'd3, 6'h3, 16'h3333, 26'h3);
    step();
    req(3'd4, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0006, 26'h0);
    step();
    idle();
    step(); step(); step();
    check("ill_count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      check("ill_a0", 64'(seen[0]), 64'h0);
      check("ill_a1", 64'(seen[1]), 64'h4);
    end
    check("ill_sticky", 64'(illegal), 64'd1);

    // Address wrap on the high-base instance.
    do_reset();
    seen_w.delete();
    req(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0);
    step();
    req(3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0020, 26'h0);
    step();
    idle();
    step(); step();
    check("wrap_count", 64'(seen_w.size()), 64'd2);
    if (seen_w.size() == 2) begin
      check("wrap_a0", 64'(seen_w[0]), 64'hFFFF_FFFC);
      check("wrap_a1", 64'(seen_w[1]), 64'h0);
    end

    // Reset with a full buffer and illegal set.
    do_reset();
    out_ready = 1'b0;
    req(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    step();
    req(3'd2, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'h0040, 26'h0);
    step();
    req(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000123);
    step();
    check("mr_full", 64'(in_ready), 64'd0);
    check("mr_ill", 64'(illegal), 64'd1);
    do_reset();
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_illegal", 64'(illegal), 64'd0);
    check("mr_instr", 64'(out_instr), 64'd0);
    out_ready = 1'b1;
    req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    step();
    idle();
    check("mr_addr", 64'(out_addr), 64'h0);
    check("mr_addr_w", 64'(out_addr_w), 64'(BASE_W));
    step();

    // Random traffic with random backpressure and rare resets.
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        req(($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
            5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
            16'($urandom), 26'($urandom));
      end else begin
        idle();
      end
      step();
    end
    reset = 1'b0;
    idle();
    out_ready = 1'b1;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
